// File: rtl/input_conditioner_if.sv
// Purpose: bundles the conditioner's raw user inputs and its conditioned outputs.
//   sw         : raw 8-bit slide-switch value (unsynchronized)
//   btn_n      : raw step pushbutton, 0 = pressed (unsynchronized)
//   imm8       : switch value captured at the last qualified press
//   step       : one-cycle pulse per qualified press
//   step_count : number of step pulses since reset (wraps)
//   busy       : high while a press or release is being qualified
// master drives the raw inputs (board/bench side); slave is the conditioner.
interface input_conditioner_if;
  localparam int unsigned SW_W  = 8;
  localparam int unsigned CNT_W = 16;

  logic [SW_W-1:0]  sw;
  logic             btn_n;
  logic [SW_W-1:0]  imm8;
  logic             step;
  logic [CNT_W-1:0] step_count;
  logic             busy;

  modport master (
    output sw,
    output btn_n,
    input  imm8,
    input  step,
    input  step_count,
    input  busy
  );

  modport slave (
    input  sw,
    input  btn_n,
    output imm8,
    output step,
    output step_count,
    output busy
  );
endinterface

// File: rtl/input_conditioner.sv
// Purpose: synchronizes the slide switches and step button, debounces the
// button with a four-state FSM and, on every qualified press, emits one step
// pulse, latches the switch value as an immediate and bumps a step counter.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-low reset; deassertion is synchronized
//   io    : input_conditioner_if.slave (sw, btn_n in; imm8, step,
//           step_count, busy out)
module input_conditioner #(
  parameter int unsigned DEB_LIMIT = 500000,
  parameter int unsigned DEB_CNT_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input_conditioner_if.slave io
);

  localparam int unsigned SW_W  = 8;
  localparam int unsigned CNT_W = 16;
  localparam logic [DEB_CNT_W-1:0] LIMIT_M1 = DEB_CNT_W'(DEB_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic                 run_q;
  logic [SW_W-1:0]      sw_meta_q;
  logic [SW_W-1:0]      sw_s_q;
  logic                 btn_n_meta_q;
  logic                 btn_n_sync_q;
  logic                 btn_s;

  state_e               state_q;
  state_e               state_d;
  logic [DEB_CNT_W-1:0] cnt_q;
  logic [DEB_CNT_W-1:0] cnt_d;
  logic                 qualify_c;
  logic                 busy_c;

  logic [SW_W-1:0]      imm8_q;
  logic                 step_q;
  logic [CNT_W-1:0]     step_count_q;
  logic                 busy_q;

  // Reset release gate: nothing else updates until the edge after this sets,
  // so the first real state update is the second edge after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Two-flop synchronizers; button flops reset to the released level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta_q    <= '0;
      sw_s_q       <= '0;
      btn_n_meta_q <= 1'b1;
      btn_n_sync_q <= 1'b1;
    end else if (run_q) begin
      sw_meta_q    <= io.sw;
      sw_s_q       <= sw_meta_q;
      btn_n_meta_q <= io.btn_n;
      btn_n_sync_q <= btn_n_meta_q;
    end
  end

  assign btn_s = ~btn_n_sync_q;

  // Debounce FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (run_q) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debounce FSM next state; the counter is cleared whenever a wait state is
  // left so it only ever runs 0..DEB_LIMIT-1 inside a wait state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qualify_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LIMIT_M1) begin
          state_d   = PRESSED;
          cnt_d     = '0;
          qualify_c = 1'b1;
        end else begin
          cnt_d = cnt_q + DEB_CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == LIMIT_M1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DEB_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_c = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
  end

  // Registered outputs; busy is taken from the next state so it tracks the
  // FSM state exactly rather than lagging it by a cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imm8_q       <= '0;
      step_q       <= 1'b0;
      step_count_q <= '0;
      busy_q       <= 1'b0;
    end else if (run_q) begin
      step_q <= qualify_c;
      busy_q <= busy_c;
      if (qualify_c) begin
        imm8_q       <= sw_s_q;
        step_count_q <= step_count_q + CNT_W'(1);
      end
    end
  end

  assign io.imm8       = imm8_q;
  assign io.step       = step_q;
  assign io.step_count = step_count_q;
  assign io.busy       = busy_q;

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEB_LIMIT, default 500000, debounce qualification time in clk cycles (10 ms at 50 MHz); legal range 2 to 2^DEB_CNT_W-1.
REQ-002 Parameter DEB_CNT_W, default 20, debounce counter width in bits.
REQ-003 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port sw  input  8  raw, unsynchronized slide-switch value.
REQ-006 Port btn_n  input  1  raw, unsynchronized step pushbutton; 0 = pressed.
REQ-007 Port imm8  output  8  switch value captured at the last qualified press; feeds the regfile/ALU immediate.
REQ-008 Port step  output  1  one-cycle pulse per qualified press; advances the downstream sequencer.
REQ-009 Port step_count  output  16  number of step pulses issued since reset.
REQ-010 Port busy  output  1  high while a press or release is being qualified.

Function
REQ-011 sw and btn_n SHALL each pass through a two-flop synchronizer; only synchronized values (sw_s, btn_s = ~synchronized btn_n) are used internally.
REQ-012 Debounce FSM SHALL have exactly four states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 IDLE: btn_s=1 -> PRESS_WAIT with counter cleared to 0; otherwise remain.
REQ-014 PRESS_WAIT: btn_s=0 -> IDLE (bounce rejected, no pulse); btn_s=1 and counter=DEB_LIMIT-1 -> PRESSED; otherwise counter increments.
REQ-015 PRESSED: btn_s=0 -> RELEASE_WAIT with counter cleared to 0; otherwise remain (holding the button SHALL NOT generate further pulses).
REQ-016 RELEASE_WAIT: btn_s=1 -> PRESSED (release bounce, no pulse); btn_s=0 and counter=DEB_LIMIT-1 -> IDLE; otherwise counter increments.
REQ-017 step SHALL be a registered output, high for exactly the one cycle following the PRESS_WAIT->PRESSED transition edge, low at all other times.
REQ-018 On that same edge imm8 SHALL load sw_s; imm8 SHALL hold its value at all other times.
REQ-019 On that same edge step_count SHALL increment by 1, wrapping 16'hFFFF -> 16'h0000 with no other effect.
REQ-020 Latency: a clean raw press stable before rising edge N SHALL produce step high during the cycle after edge N+DEB_LIMIT+2.
REQ-021 busy SHALL be high exactly when the FSM is in PRESS_WAIT or RELEASE_WAIT.
REQ-022 A switch change during PRESS_WAIT SHALL be captured if it is present in sw_s on the qualifying edge; sw changes at any other time SHALL NOT affect imm8.
REQ-023 Counter SHALL never exceed DEB_LIMIT-1 and SHALL NOT wrap.

Reset
REQ-024 While rst=0, regardless of clk: FSM=IDLE, counter=0, imm8=8'h00, step=0, step_count=16'h0000, busy=0, btn synchronizer flops=released, sw synchronizer flops=0.
REQ-025 Reset asserted mid-qualification (PRESS_WAIT) SHALL abort it with no step pulse; after release, a still-held button SHALL be qualified from counter 0.
REQ-026 Reset deassertion SHALL be synchronized; the first state update occurs on the second rising clk edge after rst rises.

Verification (DEB_LIMIT=4)
REQ-027 Reset, sw=8'hA5, clean press held 20 cycles -> one step pulse at edge N+6, imm8=8'hA5, step_count=1, busy high 4 cycles.
REQ-028 Press for 3 cycles then release (bounce) -> no step, imm8 unchanged, FSM back to IDLE, busy low.
REQ-029 Press, then 2-cycle release glitch during PRESSED, then hold -> exactly one step total; second full release/press cycle -> step_count=2.
REQ-030 sw=8'hFF on press, sw=8'h00 changed while PRESSED -> imm8 stays 8'hFF until the next qualified press.
REQ-031 Force step_count to 16'hFFFF via 65535 presses (or accelerated bench) then one press -> step_count=16'h0000, step pulses once.
REQ-032 Assert rst during PRESS_WAIT with button held -> all outputs 0 immediately; after release, step fires 6 edges after the first active edge.
